// File: rtl/tc_io_pkg.sv
// tc_io_pkg: shared constants, UART state encoding and helpers for the TinyComp UART device.
package tc_io_pkg;
  localparam logic [3:0] DATA_OFS = 4'd0;
  localparam logic [3:0] STAT_OFS = 4'd1;
  localparam int RX_AVAIL = 0;
  localparam int TX_SPACE = 1;
  localparam int TX_BUSY = 2;
  localparam int OVERRUN = 3;
  localparam int FRAMING = 4;
  localparam int FRAME_BITS = 10;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  function automatic logic [2:0] sat7(input int unsigned c);
    return (c > 7) ? 3'd7 : c[2:0];
  endfunction
endpackage

// File: rtl/tc_uart_fifo.sv
// tc_uart_fifo: synchronous FIFO; a push while full is accepted only if a pop frees a slot in the same cycle.
module tc_uart_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign head_o = mem_q[rp_q];
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= do_push ? wp_q + 1'b1 : wp_q;
      rp_q <= do_pop ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/tc_uart_io.sv
// tc_uart_io: 8N1 UART on the TinyComp I/O bus; data register at BASE_ADDR, status at BASE_ADDR+1.
module tc_uart_io
  import tc_io_pkg::*;
#(
  parameter logic [3:0] BASE_ADDR = 4'd2,
  parameter int DIVISOR = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  IOaddr,
  input  logic        IOread,
  input  logic        IOwrite,
  input  logic [31:0] OutValue,
  output logic [31:0] InValue,
  output logic        InReady,
  input  logic        rxd,
  output logic        txd
);
  localparam int DW = $clog2(DIVISOR);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DW-1:0] BIT_END = DW'(DIVISOR - 1);
  localparam logic [DW-1:0] HALF = DW'(DIVISOR / 2 - 1);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);
  logic sel_d, sel_s, rd, wr;
  logic tx_push, tx_pop, tx_full, tx_empty, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic [31:0] status;
  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [DW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic tx_tick, rx_tick;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic rx_wait_q, rx_wait_d, rx_push_q, rx_push_d, ferr_set;
  logic ovr_q, ovr_d, ferr_q, ferr_d;
  logic unused;
  assign unused = ^{OutValue[31:8], tx_count};
  assign sel_d = IOaddr == BASE_ADDR + DATA_OFS;
  assign sel_s = IOaddr == BASE_ADDR + STAT_OFS;
  assign wr = IOwrite;
  assign rd = IOread & ~IOwrite;
  assign tx_push = sel_d & wr & ~tx_full;
  assign rx_pop = sel_d & rd & ~rx_empty;
  tc_uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(Clock), .rst(Reset), .push_i(tx_push), .pop_i(tx_pop), .din_i(OutValue[7:0]),
    .head_o(tx_head), .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty)
  );
  tc_uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(Clock), .rst(Reset), .push_i(rx_push_q), .pop_i(rx_pop), .din_i(rx_sh_q),
    .head_o(rx_head), .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
  );
  always_comb begin
    status = '0;
    status[RX_AVAIL] = ~rx_empty;
    status[TX_SPACE] = ~tx_full;
    status[TX_BUSY] = (tx_state_q != U_IDLE) | ~tx_empty;
    status[OVERRUN] = ovr_q;
    status[FRAMING] = ferr_q;
    status[7:5] = sat7(32'(rx_count));
  end
  assign InValue = (sel_d & rd) ? (rx_empty ? 32'd0 : {24'd0, rx_head}) : (sel_s & rd) ? status : 32'd0;
  assign InReady = (sel_d & rd) ? ~rx_empty : (sel_d & wr) ? ~tx_full : sel_s & (IOread | IOwrite);
  assign tx_tick = tx_cnt_q == BIT_END;
  assign txd = (tx_state_q == U_START) ? 1'b0 : (tx_state_q == U_DATA) ? tx_sh_q[0] : 1'b1;
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_pop = 1'b0;
    case (tx_state_q)
      U_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop = 1'b1;
          tx_sh_d = tx_head;
          tx_state_d = U_START;
        end
      end
      U_START: if (tx_tick) begin
        tx_bit_d = '0;
        tx_state_d = U_DATA;
      end
      U_DATA: if (tx_tick) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_state_d = (tx_bit_q == LAST_BIT) ? U_STOP : U_DATA;
      end
      U_STOP: tx_state_d = tx_tick ? U_IDLE : U_STOP;
      default: tx_state_d = U_IDLE;
    endcase
  end
  assign rx_tick = rx_cnt_q == BIT_END;
  // A low stop bit parks in STOP until the line is high so a break cannot start a bogus frame.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_wait_d = rx_wait_q;
    rx_push_d = 1'b0;
    ferr_set = 1'b0;
    case (rx_state_q)
      U_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_s2_q) rx_state_d = U_START;
      end
      U_START: if (rx_cnt_q == HALF) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_state_d = rx_s2_q ? U_IDLE : U_DATA;
      end
      U_DATA: if (rx_tick) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_state_d = (rx_bit_q == LAST_BIT) ? U_STOP : U_DATA;
      end
      U_STOP: if (rx_wait_q) begin
        rx_cnt_d = '0;
        rx_wait_d = ~rx_s2_q;
        rx_state_d = rx_s2_q ? U_IDLE : U_STOP;
      end else if (rx_tick) begin
        rx_push_d = rx_s2_q;
        ferr_set = ~rx_s2_q;
        rx_wait_d = ~rx_s2_q;
        rx_state_d = rx_s2_q ? U_IDLE : U_STOP;
      end
      default: rx_state_d = U_IDLE;
    endcase
  end
  assign ovr_d = (ovr_q & ~(sel_s & wr & OutValue[OVERRUN])) | (rx_push_q & rx_full & ~rx_pop);
  assign ferr_d = (ferr_q & ~(sel_s & wr & OutValue[FRAMING])) | ferr_set;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      tx_state_q <= U_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      rx_state_q <= U_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_wait_q <= 1'b0;
      rx_push_q <= 1'b0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_wait_q <= rx_wait_d;
      rx_push_q <= rx_push_d;
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
    end
endmodule

// File: tb/tb_tc_uart_io.sv
// tb_tc_uart_io: random bus and serial traffic checked against a queue-based model of the UART device.
module tb_tc_uart_io;
  logic Clock = 0, Reset = 1, IOread = 0, IOwrite = 0, rxd = 1;
  logic [3:0] IOaddr = 0;
  logic [31:0] OutValue = 0;
  logic [31:0] InValue;
  logic InReady, txd;
  int total = 0, bad = 0;
  logic [7:0] txq[$], tx_exp[$], tx_got[$], rxq[$];
  int cyc = 0, tx_free = 0, rst_cnt = 0;
  bit ovr = 0, ferr = 0;

  tc_uart_io #(.BASE_ADDR(4'd2), .DIVISOR(4), .FIFO_DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .IOaddr(IOaddr), .IOread(IOread), .IOwrite(IOwrite),
    .OutValue(OutValue), .InValue(InValue), .InReady(InReady), .rxd(rxd), .txd(txd)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // TX model: a byte leaves the FIFO one cycle after the shifter is free, and a frame plus its idle gap takes 41 cycles.
  always @(posedge Clock or posedge Reset) begin
    bit pop, push;
    if (Reset) begin
      txq.delete();
      tx_free = 0;
    end else begin
      pop = cyc >= tx_free && txq.size() > 0;
      push = IOwrite && IOaddr == 4'd2 && txq.size() < 4;
      if (pop) begin
        void'(txq.pop_front());
        tx_free = cyc + 41;
      end
      if (push) begin
        txq.push_back(OutValue[7:0]);
        tx_exp.push_back(OutValue[7:0]);
      end
      cyc++;
    end
  end

  function automatic logic [31:0] status_m();
    logic [31:0] s = 0;
    int n = rxq.size();
    s[0] = n > 0;
    s[1] = txq.size() < 4;
    s[2] = cyc < tx_free || txq.size() > 0;
    s[3] = ovr;
    s[4] = ferr;
    s[7:5] = 3'((n > 7) ? 7 : n);
    return s;
  endfunction

  // Serial decoder for txd, sampling each bit in its middle.
  always begin
    int r0;
    logic [7:0] b;
    @(negedge txd);
    r0 = rst_cnt;
    repeat (2) @(negedge Clock);
    chk("tx_start", 32'(txd), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge Clock);
      b[i] = txd;
    end
    repeat (4) @(negedge Clock);
    if (r0 == rst_cnt) begin
      chk("tx_stop", 32'(txd), 1);
      tx_got.push_back(b);
    end
  end

  task automatic io(input logic [3:0] a, input logic r, input logic w, input logic [31:0] v,
                    output logic [31:0] iv, output logic ir, output logic td);
    logic [31:0] eiv;
    logic eir, rdd;
    @(negedge Clock);
    IOaddr = a; IOread = r; IOwrite = w; OutValue = v;
    #1;
    rdd = r && !w;
    eiv = 0;
    eir = 0;
    if (a == 4'd2 && rdd) begin
      eir = rxq.size() > 0;
      if (rxq.size() > 0) eiv = {24'd0, rxq[0]};
    end else if (a == 4'd2 && w) eir = txq.size() < 4;
    else if (a == 4'd3) begin
      eir = r || w;
      if (rdd) eiv = status_m();
    end
    iv = InValue; ir = InReady; td = txd;
    chk($sformatf("invalue a=%0d r=%0b w=%0b", a, r, w), iv, eiv);
    chk($sformatf("inready a=%0d r=%0b w=%0b", a, r, w), 32'(ir), 32'(eir));
    @(posedge Clock);
    if (a == 4'd2 && rdd && rxq.size() > 0) void'(rxq.pop_front());
    if (a == 4'd3 && w) begin
      if (v[3]) ovr = 0;
      if (v[4]) ferr = 0;
    end
    #1;
    IOread = 0; IOwrite = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int j = 0; j < 10; j++)
      repeat (4) begin
        @(negedge Clock);
        rxd = (j == 0) ? 1'b0 : (j == 9) ? stop : b[j-1];
      end
    repeat (4) begin
      @(negedge Clock);
      rxd = 1;
    end
    if (!stop) ferr = 1;
    else if (rxq.size() >= 4) ovr = 1;
    else rxq.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1;
    #1;
    chk("rst_txd", 32'(txd), 1);
    rst_cnt++;
    @(negedge Clock);
    Reset = 0;
    rxq.delete();
    ovr = 0;
    ferr = 0;
  endtask

  initial begin
    logic [31:0] iv;
    logic ir, td;
    int flips, acc, guard, n;
    logic [7:0] a5;
    repeat (3) @(negedge Clock);
    Reset = 0;
    chk("por_txd", 32'(txd), 1);
    io(4'd3, 1, 0, 0, iv, ir, td);
    chk("por_status", iv, 32'h2);

    io(4'd2, 0, 1, 32'h5A, iv, ir, td);
    repeat (15) @(negedge Clock);
    do_reset();
    io(4'd3, 1, 0, 0, iv, ir, td);
    chk("rst_status", iv, 32'h2);
    flips = 0;
    repeat (50) begin
      @(negedge Clock);
      if (txd !== 1'b1) flips++;
    end
    chk("rst_quiet", flips, 0);
    tx_exp.delete();
    tx_got.delete();

    a5 = 8'hA5;
    io(4'd2, 0, 1, 32'hA5, iv, ir, td);
    chk("a5_accept", 32'(ir), 1);
    for (int c = 0; c < 42; c++) begin
      io(4'd3, 1, 0, 0, iv, ir, td);
      chk($sformatf("a5_txd c=%0d", c), 32'(td),
          32'((c == 0) ? 1'b1 : (c <= 4) ? 1'b0 : (c <= 36) ? a5[(c-5)/4] : 1'b1));
      chk($sformatf("a5_busy c=%0d", c), 32'(iv[2]), 32'(c <= 40));
    end

    acc = 0;
    for (int i = 1; i <= 5; i++) begin
      io(4'd2, 0, 1, 32'(i), iv, ir, td);
      acc += int'(ir);
    end
    chk("b2b_min_accepted", 32'(acc >= 4), 1);

    send_frame(8'h3C, 1);
    io(4'd3, 1, 0, 0, iv, ir, td);
    chk("rx_status_avail", iv[7:0] & 8'hE1, 8'h21);
    io(4'd2, 1, 0, 0, iv, ir, td);
    chk("rx_data", iv, 32'h3C);
    chk("rx_ready", 32'(ir), 1);
    io(4'd2, 1, 0, 0, iv, ir, td);
    chk("rx_empty_data", iv, 0);
    chk("rx_empty_ready", 32'(ir), 0);

    for (int i = 0; i < 5; i++) send_frame(8'(8'h40 + i), 1);
    io(4'd3, 1, 0, 0, iv, ir, td);
    chk("ovr_set", 32'(iv[3]), 1);
    for (int i = 0; i < 4; i++) begin
      io(4'd2, 1, 0, 0, iv, ir, td);
      chk("ovr_read", iv, 32'(8'h40 + i));
    end
    io(4'd3, 0, 1, 32'h08, iv, ir, td);
    io(4'd3, 1, 0, 0, iv, ir, td);
    chk("ovr_clear", 32'(iv[3]), 0);

    send_frame(8'($urandom), 0);
    io(4'd3, 1, 0, 0, iv, ir, td);
    chk("ferr_set", 32'(iv[4]), 1);
    chk("ferr_nobyte", 32'(iv[0]), 0);
    io(4'd3, 0, 1, 32'h10, iv, ir, td);
    @(negedge Clock);
    rxd = 0;
    @(negedge Clock);
    rxd = 1;
    repeat (12) @(negedge Clock);
    io(4'd3, 1, 0, 0, iv, ir, td);
    chk("glitch_nobyte", 32'(iv[0]), 0);
    chk("glitch_noerr", 32'(iv[4]), 0);

    for (int k = 0; k < 80; k++) begin
      n = $urandom_range(0, 6);
      case (n)
        0: io(4'd2, 0, 1, $urandom, iv, ir, td);
        1: io(4'd2, 1, 0, 0, iv, ir, td);
        2: io(4'd3, 1, 0, 0, iv, ir, td);
        3: io(4'd3, 0, 1, $urandom, iv, ir, td);
        4: send_frame(8'($urandom), 1'($urandom_range(0, 7) != 0));
        5: repeat ($urandom_range(0, 20)) @(negedge Clock);
        default: io(4'($urandom), 1'($urandom), 1'($urandom), $urandom, iv, ir, td);
      endcase
    end

    guard = 0;
    while ((txq.size() > 0 || cyc < tx_free) && guard < 5000) begin
      @(negedge Clock);
      guard++;
    end
    chk("drain_timeout", 32'(guard < 5000), 1);
    repeat (5) @(negedge Clock);
    chk("tx_count", tx_got.size(), tx_exp.size());
    for (int i = 0; i < tx_got.size() && i < tx_exp.size(); i++)
      chk($sformatf("tx_byte %0d", i), 32'(tx_got[i]), 32'(tx_exp[i]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
